pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have port wb_clk_i, input, 1 bit: sole clock, all state on its rising edge.
REQ-002 SHALL have port wb_rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have Wishbone slave ports wbs_cyc_i, wbs_stb_i, wbs_we_i (in, 1 bit each), wbs_sel_i (in, 4 bits), wbs_adr_i (in, 32 bits), wbs_dat_i (in, 32 bits), wbs_ack_o (out, 1 bit) and wbs_dat_o (out, 32 bits), all classic single-access.
REQ-004 SHALL have port pwm_out, output, 12 bits: one PWM waveform per channel.
REQ-005 SHALL have port irq, output, 1 bit: period-wrap interrupt, level, active-high.

Function
REQ-006 SHALL decode wbs_adr_i[7:2] only and ignore all other address bits; the map is: 0x00 CTRL (bit0 EN, bits15:8 PRESCALE), 0x04 PERIOD[15:0], 0x08 STATUS (bit0 PEND, bit1 IRQ_EN), 0x0C POLARITY[11:0], 0x10–0x3C DUTY0–DUTY11[15:0].
REQ-007 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after wbs_cyc_i & wbs_stb_i is sampled high with ack low; there SHALL be no back-to-back ack.
REQ-008 SHALL apply a write only on the ack cycle; byte lanes SHALL follow wbs_sel_i; unmapped writes SHALL be dropped.
REQ-009 SHALL return the register value on wbs_dat_o during the ack cycle, with unused bits and unmapped addresses read as 0; outside ack wbs_dat_o SHALL be 0.
REQ-010 SHALL clear PEND when STATUS is written with bit0=1 (write-1-to-clear); IRQ_EN SHALL be plain read/write.
REQ-011 SHALL run an 8-bit prescaler while EN=1, counting 0..PRESCALE; tick SHALL be 1 in the cycle the count equals PRESCALE, after which the count returns to 0. PRESCALE=0 gives a tick every cycle.
REQ-012 SHALL run a 16-bit counter CNT that advances on tick from 0 to PERIOD_SH and wraps to 0, giving a PWM period of (PERIOD_SH+1)×(PRESCALE+1) cycles.
REQ-013 SHALL load the shadow registers PERIOD_SH and DUTY_SH[n] from the live registers only at wrap (the tick with CNT==PERIOD_SH) or while EN=0; bus writes SHALL never glitch the current period.
REQ-014 SHALL set PEND on every wrap; a wrap coinciding with a W1C write SHALL leave PEND=1 (set wins).
REQ-015 SHALL drive irq = PEND & IRQ_EN, combinational from registers.
REQ-016 SHALL compute raw[n] = EN & (CNT < DUTY_SH[n]) as an unsigned compare: DUTY=0 gives constant low, DUTY>PERIOD_SH gives constant high while enabled.
REQ-017 SHALL register pwm_out from raw (after polarity, REQ-022), giving one cycle of latency from CNT to the pin.
REQ-018 SHALL, on an EN 1→0 write, zero the prescaler and CNT on the next edge; a later 0→1 SHALL start at CNT=0 with shadows equal to the live values.
REQ-019 SHALL, on a PERIOD write that lowers PERIOD below the current CNT, have no effect until the next wrap, because the shadow governs.

Reset
REQ-020 SHALL, while wb_rst_n_i=0, immediately force all registers, shadows, counters and PEND to 0, and drive pwm_out=0, irq=0, wbs_ack_o=0 and wbs_dat_o=0. Release SHALL be synchronised internally by a two-flop deassert synchroniser, and the first valid access SHALL be the third edge after release.
REQ-021 SHALL, on reset during a bus access, drop the ack, leave the transaction unacknowledged and discard any write.

Configuration
REQ-022 SHALL, with PWM_BANK_POLARITY_EN defined, implement POLARITY as read/write with pwm_out[n] = raw[n] ^ POLARITY[n], including when EN=0.
REQ-023 SHALL, with PWM_BANK_POLARITY_EN undefined, create no POLARITY register: 0x0C SHALL read 0, writes SHALL be ignored, and pwm_out = raw.

Verification
REQ-024 SHALL cover: PRESCALE=0, PERIOD=9, DUTY0=3, EN=1 -> pwm_out[0] high 3 cycles and low 7 cycles, period 10.
REQ-025 SHALL cover: a DUTY0 write of 7 mid-period -> the current period stays 3 high; the next period is 7 high.
REQ-026 SHALL cover: PRESCALE=1, PERIOD=3, IRQ_EN=1 -> irq rises every 8 cycles; W1C of STATUS drops irq; W1C in the same cycle as a wrap leaves irq=1.
REQ-027 SHALL cover: DUTY1=0 and DUTY2=0xFFFF with PERIOD=9 -> ch1 constant 0 and ch2 constant 1; after EN=0 both are 0 within 2 cycles.
REQ-028 SHALL cover: reset asserted mid-write to PERIOD -> outputs 0 immediately, PERIOD reads 0 after release, and no ack is issued.
REQ-029 SHALL cover: with PWM_BANK_POLARITY_EN defined, POLARITY=0x001 and EN=0 -> pwm_out=0x001; with the macro undefined, 0x0C reads 0 after a write of 0xFFF.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: Wishbone-controlled bank of 12 PWM channels sharing one prescaler and period counter.
// Defining PWM_BANK_POLARITY_EN adds a per-channel output polarity register at 0x0C.
module pwm_bank (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [11:0] pwm_out,
  output logic        irq
);

  localparam int unsigned NumCh = 12;

  // Reset: asserts immediately, releases two edges after wb_rst_n_i rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  // Bus handshake and address decode
  logic       ack_q, ack_d;
  logic       bus_req, wr_en;
  logic [5:0] word;
  logic [3:0] duty_idx;
  logic       sel_ctrl, sel_period, sel_status, sel_pol, sel_duty;

  assign bus_req    = wbs_cyc_i & wbs_stb_i;
  assign wr_en      = ack_q & bus_req & wbs_we_i;
  assign word       = wbs_adr_i[7:2];
  assign duty_idx   = word[3:0] - 4'd4;
  assign sel_ctrl   = (word == 6'd0);
  assign sel_period = (word == 6'd1);
  assign sel_status = (word == 6'd2);
  assign sel_pol    = (word == 6'd3);
  assign sel_duty   = (word[5:4] == 2'b00) && (word[3:2] != 2'b00);

  always_comb begin
    ack_d = bus_req & ~ack_q;
  end

  logic unused_bus;
  assign unused_bus = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  function automatic logic [15:0] merge16(input logic [15:0] old_val, input logic [15:0] wdat,
                                          input logic [1:0] lanes);
    logic [15:0] res;
    res = old_val;
    if (lanes[0]) res[7:0] = wdat[7:0];
    if (lanes[1]) res[15:8] = wdat[15:8];
    return res;
  endfunction

  // Live registers
  logic                   en_q, en_d;
  logic [7:0]             prescale_q, prescale_d;
  logic [15:0]            period_q, period_d;
  logic                   irq_en_q, irq_en_d;
  logic                   pend_q, pend_d;
  logic [NumCh-1:0][15:0] duty_q, duty_d;
  logic [NumCh-1:0]       pol;

  // Shadows and counters
  logic [15:0]            period_sh_q, period_sh_d;
  logic [NumCh-1:0][15:0] duty_sh_q, duty_sh_d;
  logic [7:0]             presc_cnt_q, presc_cnt_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   tick, wrap;
  logic [NumCh-1:0]       raw;
  logic [NumCh-1:0]       pwm_q, pwm_d;

  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    irq_en_d   = irq_en_q;
    duty_d     = duty_q;
    if (wr_en) begin
      if (sel_ctrl) begin
        if (wbs_sel_i[0]) en_d = wbs_dat_i[0];
        if (wbs_sel_i[1]) prescale_d = wbs_dat_i[15:8];
      end
      if (sel_period) period_d = merge16(period_q, wbs_dat_i[15:0], wbs_sel_i[1:0]);
      if (sel_status && wbs_sel_i[0]) irq_en_d = wbs_dat_i[1];
      if (sel_duty) begin
        duty_d[duty_idx] = merge16(duty_q[duty_idx], wbs_dat_i[15:0], wbs_sel_i[1:0]);
      end
    end
  end

  always_comb begin
    presc_cnt_d = '0;
    cnt_d       = '0;
    tick        = 1'b0;
    wrap        = 1'b0;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    if (en_q) begin
      tick        = (presc_cnt_q == prescale_q);
      presc_cnt_d = tick ? 8'd0 : presc_cnt_q + 8'd1;
      cnt_d       = cnt_q;
      if (tick) begin
        if (cnt_q == period_sh_q) begin
          wrap  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end
    // Shadows only move at a period boundary so bus writes never distort a running period.
    if (wrap || !en_q) begin
      period_sh_d = period_q;
      duty_sh_d   = duty_q;
    end
  end

  // A wrap in the same cycle as a W1C leaves PEND set.
  always_comb begin
    pend_d = pend_q;
    if (wr_en && sel_status && wbs_sel_i[0] && wbs_dat_i[0]) pend_d = 1'b0;
    if (wrap) pend_d = 1'b1;
  end

  always_comb begin
    for (int n = 0; n < NumCh; n++) begin
      raw[n] = en_q & (cnt_q < duty_sh_q[n]);
    end
    pwm_d = raw ^ pol;
  end

`ifdef PWM_BANK_POLARITY_EN
  logic [NumCh-1:0] pol_q, pol_d;

  always_comb begin
    pol_d = pol_q;
    if (wr_en && sel_pol) begin
      if (wbs_sel_i[0]) pol_d[7:0] = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) pol_d[11:8] = wbs_dat_i[11:8];
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pol_q <= '0;
    end else begin
      pol_q <= pol_d;
    end
  end

  assign pol = pol_q;
`else
  assign pol = '0;
`endif

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      en_q        <= 1'b0;
      prescale_q  <= '0;
      period_q    <= '0;
      irq_en_q    <= 1'b0;
      pend_q      <= 1'b0;
      duty_q      <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      pwm_q       <= '0;
    end else begin
      ack_q       <= ack_d;
      en_q        <= en_d;
      prescale_q  <= prescale_d;
      period_q    <= period_d;
      irq_en_q    <= irq_en_d;
      pend_q      <= pend_d;
      duty_q      <= duty_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
    end
  end

  // Read data is only driven during the ack cycle.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (sel_ctrl)   rdata = {16'h0, prescale_q, 7'h0, en_q};
    if (sel_period) rdata = {16'h0, period_q};
    if (sel_status) rdata = {30'h0, irq_en_q, pend_q};
    if (sel_pol)    rdata = {20'h0, pol};
    if (sel_duty)   rdata = {16'h0, duty_q[duty_idx]};
  end

  always_comb begin
    wbs_dat_o = ack_q ? rdata : 32'h0;
  end

  assign wbs_ack_o = ack_q;
  assign pwm_out   = pwm_q;
  assign irq       = pend_q & irq_en_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: bus map, PWM waveforms, shadow timing, IRQ and reset,
// with expected waveforms computed from period arithmetic.
`timescale 1ns/1ps
module tb_pwm_bank;

  localparam int NumCh = 12;
  localparam logic [31:0] AdrCtrl   = 32'h00;
  localparam logic [31:0] AdrPeriod = 32'h04;
  localparam logic [31:0] AdrStatus = 32'h08;
  localparam logic [31:0] AdrPol    = 32'h0C;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = '0;
  logic [31:0] adr   = '0;
  logic [31:0] dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [11:0] pwm;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int unsigned cycle_cnt = 0;
  int unsigned base = 0;

  // Reference configuration
  int unsigned m_prescale;
  int unsigned m_period;
  int unsigned m_duty [NumCh];
  logic [11:0] m_pol = '0;

  pwm_bank dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_w),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_r),
    .pwm_out    (pwm),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
    $fatal(1, "watchdog");
  end

  // Cycle c counts edges since the enabling write landed; the pin shows CNT of the previous cycle.
  function automatic logic [11:0] exp_pwm(input int unsigned c);
    logic [11:0] r;
    int unsigned pos;
    r = '0;
    if (c > 0) begin
      pos = ((c - 1) / (m_prescale + 1)) % (m_period + 1);
      for (int n = 0; n < NumCh; n++) r[n] = (pos < m_duty[n]);
    end
    return r ^ m_pol;
  endfunction

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    checks++;
    if (!ack) begin
      errors++;
      $display("FAIL wb_write_ack adr=%h: ack=%b, wanted 1 within 20 cycles", a, ack);
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    checks++;
    if (!ack) begin
      errors++;
      $display("FAIL wb_read_ack adr=%h: ack=%b, wanted 1 within 20 cycles", a, ack);
    end
    d = dat_r;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; sel = '0;
  endtask

  task automatic clear_duty();
    for (int n = 0; n < NumCh; n++) m_duty[n] = 0;
  endtask

  task automatic configure();
    wb_write(AdrCtrl, 32'h0, 4'hF);
    wb_write(AdrPeriod, m_period, 4'h3);
    for (int n = 0; n < NumCh; n++) wb_write(32'(16 + 4 * n), m_duty[n], 4'h3);
  endtask

  task automatic enable();
    wb_write(AdrCtrl, (m_prescale << 8) | 1, 4'hF);
    base = cycle_cnt;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2 rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AdrCtrl; sel = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm !== 12'h0) begin errors++; $display("FAIL reset_pwm: got %h, wanted 000", pwm); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, wanted 0", irq); end
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b, wanted 0", ack); end
    checks++;
    if (dat_r !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h, wanted 0", dat_r); end
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (ack !== (e == 3)) begin
        errors++;
        $display("FAIL reset_release_ack edge=%0d: got %b, wanted %b", e, ack, (e == 3));
      end
    end
    checks++;
    if (dat_r !== 32'h0) begin errors++; $display("FAIL reset_ctrl_read: got %h, wanted 0", dat_r); end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; sel = '0;
    wb_read(AdrStatus, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, wanted 0", d); end
  endtask

  task automatic test_bus();
    logic [31:0] d;
    logic [15:0] v [NumCh];
    wb_write(32'hABCD_1207, 32'h1234_5678, 4'hF);
    wb_read(AdrPeriod, d);
    checks++;
    if (d !== 32'h0000_5678) begin errors++; $display("FAIL bus_alias: got %h, wanted 00005678", d); end
    wb_write(AdrPeriod, 32'hFFFF_FFFF, 4'b0010);
    wb_read(AdrPeriod, d);
    checks++;
    if (d !== 32'h0000_FF78) begin errors++; $display("FAIL bus_bytelane: got %h, wanted 0000ff78", d); end
    wb_write(AdrCtrl, 32'hFFFF_FF00, 4'hF);
    wb_read(AdrCtrl, d);
    checks++;
    if (d !== 32'h0000_FF00) begin errors++; $display("FAIL bus_ctrl_mask: got %h, wanted 0000ff00", d); end
    wb_write(AdrCtrl, 32'h0, 4'hF);
    wb_write(32'h40, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h40, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL bus_unmapped_40: got %h, wanted 0", d); end
    wb_read(32'hFC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL bus_unmapped_fc: got %h, wanted 0", d); end
    for (int n = 0; n < NumCh; n++) begin
      v[n] = 16'($urandom);
      wb_write(32'(16 + 4 * n), {16'($urandom), v[n]}, 4'hF);
    end
    for (int n = 0; n < NumCh; n++) begin
      wb_read(32'(16 + 4 * n), d);
      checks++;
      if (d !== {16'h0, v[n]}) begin
        errors++;
        $display("FAIL bus_duty%0d: got %h, wanted %h", n, d, {16'h0, v[n]});
      end
    end
    // Held request: one ack, data zero outside it, no back-to-back ack.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AdrPeriod; sel = 4'hF;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || dat_r !== 32'h0) begin
      errors++; $display("FAIL bus_pre_ack: got ack=%b dat=%h, wanted 0/0", ack, dat_r);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || dat_r !== 32'h0000_FF78) begin
      errors++; $display("FAIL bus_ack_data: got ack=%b dat=%h, wanted 1/0000ff78", ack, dat_r);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL bus_no_b2b: got ack=%b, wanted 0", ack); end
    cyc = 1'b0; stb = 1'b0; sel = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_window(input string name, input int unsigned len);
    int unsigned c;
    for (int i = 0; i < int'(len); i++) begin
      @(negedge clk);
      c = cycle_cnt - base;
      checks++;
      if (pwm !== exp_pwm(c)) begin
        errors++;
        $display("FAIL %s cycle=%0d: got %h, wanted %h", name, c, pwm, exp_pwm(c));
      end
    end
  endtask

  task automatic test_basic_pwm();
    int unsigned c;
    int highs;
    m_prescale = 0; m_period = 9; clear_duty(); m_duty[0] = 3;
    configure();
    enable();
    highs = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      c = cycle_cnt - base;
      if (c >= 1 && c <= 20) highs += int'(pwm[0]);
      checks++;
      if (pwm !== exp_pwm(c)) begin
        errors++; $display("FAIL basic_pwm cycle=%0d: got %h, wanted %h", c, pwm, exp_pwm(c));
      end
    end
    checks++;
    if (highs != 6) begin errors++; $display("FAIL basic_high_count: got %0d, wanted 6", highs); end
  endtask

  task automatic test_pwm_random();
    for (int it = 0; it < 4; it++) begin
      m_prescale = $urandom_range(0, 3);
      m_period   = $urandom_range(1, 12);
      for (int n = 0; n < NumCh; n++) begin
        m_duty[n] = ($urandom_range(0, 7) == 0) ? 32'hFFFF : $urandom_range(0, m_period + 2);
      end
      configure();
      enable();
      check_window("random_pwm", (m_period + 1) * (m_prescale + 1) * 2 + 3);
    end
  endtask

  task automatic test_duty_midperiod();
    int unsigned c, p;
    logic want;
    m_prescale = 0; m_period = 9; clear_duty(); m_duty[0] = 3;
    configure();
    enable();
    wb_write(32'h10, 32'd7, 4'h3);
    checks++;
    if (cycle_cnt - base >= 10) begin
      errors++; $display("FAIL midperiod_timing: write at cycle %0d, wanted < 10", cycle_cnt - base);
    end
    while (cycle_cnt - base < 30) begin
      @(negedge clk);
      c = cycle_cnt - base;
      p = c - 1;
      want = (p % 10) < ((p / 10 == 0) ? 3 : 7);
      checks++;
      if (pwm[0] !== want) begin
        errors++; $display("FAIL midperiod_duty cycle=%0d: got %b, wanted %b", c, pwm[0], want);
      end
    end
  endtask

  task automatic test_period_lower();
    int unsigned c, p, cnt;
    logic want;
    m_prescale = 0; m_period = 9; clear_duty(); m_duty[0] = 2;
    configure();
    enable();
    while (cycle_cnt - base < 5) @(negedge clk);
    wb_write(AdrPeriod, 32'd3, 4'h3);
    while (cycle_cnt - base < 34) begin
      @(negedge clk);
      c = cycle_cnt - base;
      p = c - 1;
      cnt = (p < 10) ? p : (p - 10) % 4;
      want = (cnt < 2);
      checks++;
      if (pwm[0] !== want) begin
        errors++; $display("FAIL period_lower cycle=%0d: got %b, wanted %b", c, pwm[0], want);
      end
    end
  endtask

  task automatic test_irq();
    int unsigned c;
    logic [31:0] d;
    m_prescale = 1; m_period = 3; clear_duty();
    configure();
    wb_write(AdrStatus, 32'h3, 4'h1);
    enable();
    do begin
      @(negedge clk);
      c = cycle_cnt - base;
      checks++;
      if (irq !== (c >= 8)) begin
        errors++; $display("FAIL irq_first cycle=%0d: got %b, wanted %b", c, irq, (c >= 8));
      end
    end while (c < 8);
    wb_write(AdrStatus, 32'h3, 4'h1);
    do begin
      @(negedge clk);
      c = cycle_cnt - base;
      checks++;
      if (irq !== (c >= 16)) begin
        errors++; $display("FAIL irq_w1c cycle=%0d: got %b, wanted %b", c, irq, (c >= 16));
      end
    end while (c < 16);
    while (cycle_cnt - base < 22) @(negedge clk);
    wb_write(AdrStatus, 32'h3, 4'h1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b, wanted 1", irq); end
    wb_read(AdrStatus, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL irq_status: got %h, wanted 3", d); end
    wb_write(AdrStatus, 32'h1, 4'h1);
  endtask

  task automatic test_const_disable();
    int unsigned c;
    m_prescale = 0; m_period = 9; clear_duty(); m_duty[1] = 0; m_duty[2] = 32'hFFFF;
    configure();
    enable();
    while (cycle_cnt - base < 25) begin
      @(negedge clk);
      c = cycle_cnt - base;
      if (c >= 1) begin
        checks++;
        if (pwm[2:1] !== 2'b10) begin
          errors++; $display("FAIL const_channels cycle=%0d: got %b, wanted 10", c, pwm[2:1]);
        end
      end
    end
    wb_write(AdrCtrl, 32'h0, 4'hF);
    @(negedge clk);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (pwm !== 12'h0) begin
        errors++; $display("FAIL disable_zero cycle=%0d: got %h, wanted 000", i, pwm);
      end
    end
  endtask

  task automatic test_polarity();
    logic [31:0] d;
    wb_write(AdrCtrl, 32'h0, 4'hF);
`ifdef PWM_BANK_POLARITY_EN
    wb_write(AdrPol, 32'h001, 4'h3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pwm !== 12'h001) begin errors++; $display("FAIL polarity_pin: got %h, wanted 001", pwm); end
    wb_read(AdrPol, d);
    checks++;
    if (d !== 32'h001) begin errors++; $display("FAIL polarity_read: got %h, wanted 001", d); end
    wb_write(AdrPol, 32'h0, 4'h3);
`else
    wb_write(AdrPol, 32'hFFF, 4'h3);
    wb_read(AdrPol, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL polarity_absent_read: got %h, wanted 0", d); end
    @(negedge clk);
    checks++;
    if (pwm !== 12'h0) begin errors++; $display("FAIL polarity_absent_pin: got %h, wanted 000", pwm); end
`endif
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    m_prescale = 0; m_period = 9; clear_duty(); m_duty[2] = 32'hFFFF;
    configure();
    wb_write(AdrStatus, 32'h3, 4'h1);
    enable();
    while (cycle_cnt - base < 12) @(negedge clk);
    checks++;
    if (pwm[2] !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got pwm2=%b irq=%b, wanted 1/1", pwm[2], irq);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = AdrPeriod; dat_w = 32'h1234; sel = 4'h3;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL rstmid_ack_cycle: got %b, wanted 1", ack); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== 12'h0 || irq !== 1'b0 || ack !== 1'b0 || dat_r !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_immediate: got pwm=%h irq=%b ack=%b dat=%h, wanted all 0",
               pwm, irq, ack, dat_r);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack: got %b, wanted 0", ack); end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wb_read(AdrPeriod, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rstmid_period: got %h, wanted 0", d); end
    checks++;
    if (irq !== 1'b0 || pwm !== 12'h0) begin
      errors++; $display("FAIL rstmid_after: got irq=%b pwm=%h, wanted 0/000", irq, pwm);
    end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_basic_pwm();
    test_pwm_random();
    test_duty_midperiod();
    test_period_lower();
    test_irq();
    test_const_disable();
    test_polarity();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
